// File: rtl/uart_mem_cmd_bridge.sv
// UART frame decoder driving a req/busy memory port and returning DATA_BYTES response bytes per frame.
// Optional AUTOINC_EN: mem_addr post-increments after each successful WRITE request or READ_REQ capture.
module uart_mem_cmd_bridge #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_W      = 32,
  parameter int RX_TIMEOUT  = 120000,
  parameter int MEM_TIMEOUT = 4096,
  parameter int CONST_VAL   = 259
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wr_d,
  output logic                    mem_wr_req,
  output logic                    mem_rd_req,
  input  logic [8*DATA_BYTES-1:0] mem_rd_d,
  input  logic                    mem_rd_rdy,
  input  logic                    mem_busy,
  output logic                    cmd_active,
  output logic                    err_pulse,
  output logic [2:0]              dbg_state
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int CW     = $clog2(DATA_BYTES + 2);
  localparam int IW     = $clog2(RX_TIMEOUT + 1);
  localparam int MW     = $clog2(MEM_TIMEOUT + 1);

  localparam logic [CW-1:0] LP_LAST     = CW'(DATA_BYTES);
  localparam logic [IW-1:0] LP_IDLE_MAX = IW'(RX_TIMEOUT - 1);
  localparam logic [MW-1:0] LP_WAIT_MAX = MW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RX        = 3'd0,
    ST_EXEC      = 3'd1,
    ST_MEM_ISSUE = 3'd2,
    ST_MEM_WAIT  = 3'd3,
    ST_TX_DRIVE  = 3'd4,
    ST_TX_SHIFT  = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W+7:0]   r_frame;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idle;
  logic [MW-1:0]       r_wait;
  logic [DATA_W-1:0]   r_resp, r_rd_latch, r_count, r_wr_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_err_cnt, r_last_cmd, r_tx_data;
  logic                r_is_rd, r_tx_start, r_wr_req, r_rd_req, r_err;
`ifdef AUTOINC_EN
  logic                r_inc;
`endif

  logic [7:0]          w_cmd;
  logic [DATA_W-1:0]   w_payload;
  logic                w_frame_done, w_rx_to, w_issue, w_mem_to, w_rd_cap;
  logic                w_tx_go, w_tx_fall, w_bad_cmd, w_overrun;
  logic [1:0]          w_err_inc;
  logic [8:0]          w_err_sum;

  assign w_cmd     = r_frame[DATA_W+7:DATA_W];
  assign w_payload = r_frame[DATA_W-1:0];
  assign w_overrun = rx_valid && (r_state != ST_RX);
  assign w_err_inc = {1'b0, w_rx_to | w_bad_cmd | w_mem_to} + {1'b0, w_overrun};
  assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign mem_addr   = r_addr;
  assign mem_wr_d   = r_wr_d;
  assign mem_wr_req = r_wr_req;
  assign mem_rd_req = r_rd_req;
  assign err_pulse  = r_err;
  assign cmd_active = (r_state != ST_RX) || (r_cnt != '0);
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_RX;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_rx_to      = 1'b0;
    w_issue      = 1'b0;
    w_mem_to     = 1'b0;
    w_rd_cap     = 1'b0;
    w_tx_go      = 1'b0;
    w_tx_fall    = 1'b0;
    w_bad_cmd    = 1'b0;
    case (r_state)
      ST_RX: begin
        if (rx_valid) begin
          if (r_cnt == LP_LAST) begin
            w_frame_done = 1'b1;
            w_state_nxt  = ST_EXEC;
          end
        end else if (r_cnt != '0 && r_idle == LP_IDLE_MAX) begin
          w_rx_to = 1'b1;
        end
      end
      ST_EXEC: begin
        if (w_cmd == 8'h03 || w_cmd == 8'h05) begin
          w_state_nxt = ST_MEM_ISSUE;
        end else begin
          w_bad_cmd   = (w_cmd == 8'h00) || (w_cmd > 8'h08);
          w_state_nxt = ST_TX_DRIVE;
        end
      end
      ST_MEM_ISSUE: begin
        // Timeout wins so no request can leave after the abort decision.
        if (r_wait == LP_WAIT_MAX) begin
          w_mem_to    = 1'b1;
          w_state_nxt = ST_TX_DRIVE;
        end else if (!mem_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = r_is_rd ? ST_MEM_WAIT : ST_TX_DRIVE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_rd_rdy) begin
          w_rd_cap    = 1'b1;
          w_state_nxt = ST_TX_DRIVE;
        end else if (r_wait == LP_WAIT_MAX) begin
          w_mem_to    = 1'b1;
          w_state_nxt = ST_TX_DRIVE;
        end
      end
      ST_TX_DRIVE: begin
        // Start rises on ready, then holds until uart_tx drops ready to show it took the byte.
        if (!r_tx_start) begin
          w_tx_go = tx_ready;
        end else if (!tx_ready) begin
          w_tx_fall   = 1'b1;
          w_state_nxt = ST_TX_SHIFT;
        end
      end
      ST_TX_SHIFT: begin
        w_state_nxt = (r_cnt == CW'(1)) ? ST_RX : ST_TX_DRIVE;
      end
      default: w_state_nxt = ST_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame    <= '0;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_wait     <= '0;
      r_resp     <= '0;
      r_rd_latch <= '0;
      r_count    <= '0;
      r_wr_d     <= '0;
      r_addr     <= '0;
      r_err_cnt  <= '0;
      r_last_cmd <= '0;
      r_tx_data  <= '0;
      r_is_rd    <= 1'b0;
      r_tx_start <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_req   <= 1'b0;
      r_err      <= 1'b0;
`ifdef AUTOINC_EN
      r_inc      <= 1'b0;
`endif
    end else begin
      r_wr_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_err     <= (w_err_inc != 2'd0);
      r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if (mem_rd_rdy) r_rd_latch <= mem_rd_d;

      if (r_state != ST_RX || rx_valid || r_cnt == '0 || w_rx_to) r_idle <= '0;
      else                                                         r_idle <= r_idle + 1'b1;

      case (r_state)
        ST_RX: begin
          if (rx_valid) begin
            r_frame <= {r_frame[DATA_W-1:0], rx_data};
            r_cnt   <= w_frame_done ? '0 : r_cnt + 1'b1;
          end else if (w_rx_to) begin
            r_cnt <= '0;
          end
        end
        ST_EXEC: begin
          r_last_cmd <= w_cmd;
          r_wait     <= '0;
          r_cnt      <= LP_LAST;
          r_is_rd    <= (w_cmd == 8'h05);
          case (w_cmd)
            8'h01: begin
              r_addr <= w_payload[ADDR_W-1:0];
              r_resp <= w_payload;
            end
            8'h02: begin
              r_wr_d <= w_payload;
              r_resp <= w_payload;
            end
            8'h03: r_resp <= DATA_W'(8'h03);
            8'h04: r_resp <= r_rd_latch;
            8'h06: begin
              r_resp  <= r_count;
              r_count <= r_count + 1'b1;
            end
            8'h07: r_resp <= DATA_W'(CONST_VAL);
            8'h08: r_resp <= DATA_W'({r_err_cnt, r_last_cmd});
            default: r_resp <= '1;
          endcase
        end
        ST_MEM_ISSUE, ST_MEM_WAIT: begin
          r_wait <= r_wait + 1'b1;
          if (w_issue) begin
            r_wr_req <= !r_is_rd;
            r_rd_req <= r_is_rd;
          end
          if (w_mem_to) r_resp <= '1;
          if (w_rd_cap) r_resp <= mem_rd_d;
        end
        ST_TX_DRIVE: begin
          if (w_tx_go) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_resp[DATA_W-1 -: 8];
          end
          if (w_tx_fall) r_tx_start <= 1'b0;
        end
        ST_TX_SHIFT: begin
          r_resp <= r_resp << 8;
          r_cnt  <= r_cnt - 1'b1;
        end
        default: ;
      endcase

`ifdef AUTOINC_EN
      r_inc <= (w_issue && !r_is_rd) || w_rd_cap;
      if (r_inc) r_addr <= r_addr + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mem_cmd_bridge.sv
// Directed bench for uart_mem_cmd_bridge: vector table of single frames plus hand-written memory,
// timeout, overrun and mid-transmit reset sequences. A uart_tx model checks every response byte.
module tb_uart_mem_cmd_bridge;

`ifdef AUTOINC_EN
  localparam logic [31:0] AI = 32'd1;
`else
  localparam logic [31:0] AI = 32'd0;
`endif
  localparam int RXTO = 200;
  localparam int MTO  = 64;

  logic        clk = 1'b0;
  logic        rstn, rx_valid, tx_ready, tx_start, mem_wr_req, mem_rd_req;
  logic        mem_rd_rdy, mem_busy, cmd_active, err_pulse;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] mem_addr, mem_wr_d, mem_rd_d;
  logic [2:0]  dbg_state;

  uart_mem_cmd_bridge #(
    .DATA_BYTES(4), .ADDR_W(32), .RX_TIMEOUT(RXTO), .MEM_TIMEOUT(MTO), .CONST_VAL(259)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .mem_addr(mem_addr), .mem_wr_d(mem_wr_d),
    .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_rd_d(mem_rd_d),
    .mem_rd_rdy(mem_rd_rdy), .mem_busy(mem_busy), .cmd_active(cmd_active),
    .err_pulse(err_pulse), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n_tx = 0, n_errp = 0, n_wrreq = 0, n_rdreq = 0;
  bit ignore_tx = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pay;
    logic [31:0] resp;
    logic [31:0] addr;
    logic [31:0] wrd;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pay);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(pay[8*i +: 8]);
  endtask

  task automatic wait_resp(input int tx0);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cmd_active) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("resp_done", t < 3000, 1);
    check("tx_pulses", n_tx - tx0, 4);
    exp_q.delete();
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] pay, input logic [31:0] resp);
    int tx0;
    tx0 = n_tx;
    push_word(resp);
    send_frame(cmd, pay);
    wait_resp(tx0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; rx_data = 8'h00; mem_busy = 1'b0; mem_rd_rdy = 1'b0; mem_rd_d = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // uart_tx model: accepts a byte when start meets ready, then stays busy a few cycles.
  initial begin
    int hold;
    hold = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_ready = 1'b1;
      end else if (tx_start && tx_ready) begin
        n_tx++;
        if (!ignore_tx) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_tx: got %0h expected no byte", tx_data);
          end else begin
            check("tx_byte", tx_data, exp_q.pop_front());
          end
        end
        tx_ready = 1'b0;
        hold = 3;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err_pulse)  n_errp++;
      if (mem_wr_req) n_wrreq++;
      if (mem_rd_req) n_rdreq++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e0, w0, r0, tx0, first;
    bit found;

    vt[0] = '{8'h01, 32'h0000002A, 32'h0000002A, 32'h0000002A, 32'h00000000};
    vt[1] = '{8'h06, 32'h00000000, 32'h00000000, 32'h0000002A, 32'h00000000};
    vt[2] = '{8'h06, 32'h12345678, 32'h00000001, 32'h0000002A, 32'h00000000};
    vt[3] = '{8'h07, 32'h00000000, 32'h00000103, 32'h0000002A, 32'h00000000};
    vt[4] = '{8'h02, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000002A, 32'hDEADBEEF};
    vt[5] = '{8'h08, 32'h00000000, 32'h00000002, 32'h0000002A, 32'hDEADBEEF};
    vt[6] = '{8'h04, 32'h00000000, 32'h00000000, 32'h0000002A, 32'hDEADBEEF};
    vt[7] = '{8'h01, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hDEADBEEF};
    vt[8] = '{8'h08, 32'h00000000, 32'h00000001, 32'hAABBCCDD, 32'hDEADBEEF};

    rx_valid = 1'b0; rx_data = 8'h00; mem_busy = 1'b0; mem_rd_rdy = 1'b0; mem_rd_d = '0;
    rstn = 1'b0;
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr_d", mem_wr_d, 0);
    check("rst_wr_req", mem_wr_req, 0);
    check("rst_rd_req", mem_rd_req, 0);
    check("rst_cmd_active", cmd_active, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_state", dbg_state, 0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      run_frame(vt[i].cmd, vt[i].pay, vt[i].resp);
      check("vec_addr", mem_addr, vt[i].addr);
      check("vec_wr_d", mem_wr_d, vt[i].wrd);
    end

    // WRITE held off by busy for 10 cycles after the frame.
    tx0 = n_tx; w0 = n_wrreq;
    mem_busy = 1'b1;
    push_word(32'h00000003);
    send_frame(8'h03, 32'h00000000);
    repeat (10) @(negedge clk);
    check("wr_while_busy", n_wrreq - w0, 0);
    mem_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_wr_req) found = 1'b1;
    end
    check("wr_req_seen", found, 1);
    check("wr_data", mem_wr_d, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_req_width", mem_wr_req, 0);
    wait_resp(tx0);
    check("wr_req_count", n_wrreq - w0, 1);
    check("wr_addr", mem_addr, 32'hAABBCCDD + AI);

    // READ_REQ with data 5 cycles after the request.
    tx0 = n_tx;
    push_word(32'h12345678);
    send_frame(8'h05, 32'h00000000);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (mem_rd_req) found = 1'b1;
    end
    check("rd_req_seen", found, 1);
    @(negedge clk);
    check("rd_req_width", mem_rd_req, 0);
    repeat (3) @(negedge clk);
    mem_rd_d = 32'h12345678;
    mem_rd_rdy = 1'b1;
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    mem_rd_d = 32'h0BADF00D;
    wait_resp(tx0);
    run_frame(8'h04, 32'h00000000, 32'h12345678);
    check("rd_addr", mem_addr, 32'hAABBCCDD + 2 * AI);

    // Partial frame discarded after the idle timeout.
    do_reset();
    e0 = n_errp;
    send_byte(8'h07);
    send_byte(8'h00);
    first = -1;
    for (int i = 0; i < RXTO + 40; i++) begin
      @(negedge clk);
      if (err_pulse && first < 0) first = i;
    end
    check("rxto_pulses", n_errp - e0, 1);
    check("rxto_timing", (first >= RXTO - 10) && (first <= RXTO + 10), 1);
    check("rxto_idle", cmd_active, 0);
    run_frame(8'h07, 32'h00000000, 32'h00000103);
    run_frame(8'h08, 32'h00000000, 32'h00000107);

    // Read that never completes, then a write that never gets past busy.
    do_reset();
    e0 = n_errp; r0 = n_rdreq;
    run_frame(8'h05, 32'h00000000, 32'hFFFFFFFF);
    check("mto_err", n_errp - e0, 1);
    check("mto_rd_req", n_rdreq - r0, 1);
    run_frame(8'h08, 32'h00000000, 32'h00000105);
    w0 = n_wrreq;
    mem_busy = 1'b1;
    run_frame(8'h03, 32'h00000000, 32'hFFFFFFFF);
    mem_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("mto_no_wr", n_wrreq - w0, 0);
    run_frame(8'h08, 32'h00000000, 32'h00000203);

    // Unknown command with a byte injected while transmitting.
    do_reset();
    e0 = n_errp; tx0 = n_tx;
    push_word(32'hFFFFFFFF);
    send_frame(8'h99, 32'h00000000);
    t = 0;
    while (n_tx == tx0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("ovr_tx_started", t < 500, 1);
    send_byte(8'h55);
    wait_resp(tx0);
    check("ovr_err", n_errp - e0, 2);
    run_frame(8'h08, 32'h00000000, 32'h00000299);

    // Reset while a response is being sent.
    ignore_tx = 1'b1;
    tx0 = n_tx;
    send_frame(8'h07, 32'h00000000);
    t = 0;
    while (n_tx - tx0 < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_start) found = 1'b1;
    end
    check("mid_tx_start_seen", found, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_active", cmd_active, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.delete();
    ignore_tx = 1'b0;
    run_frame(8'h07, 32'h00000000, 32'h00000103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_mem_cmd_bridge.md
Name: uart_mem_cmd_bridge

Overview:
Parametrised UART-to-memory command bridge between uart_rx/uart_tx and hyper_xface (or any req/busy memory port). It decodes fixed-length frames (1 command byte + DATA_BYTES payload, MSB first) and drives single-cycle memory requests. It returns exactly DATA_BYTES response bytes per frame, with no padding byte. New over the previous generation:
- Width parameters.
- Inter-byte frame timeout.
- Busy-aware request issue.
- Blocking read with memory timeout.
- Error/status counters.

Parameters:
DATA_BYTES, 4, payload/response/memory word size in bytes (>=2); DATA_W = 8*DATA_BYTES
ADDR_W, 32, memory address width (<= DATA_W; taken from payload LSBs)
RX_TIMEOUT, 120000, idle clocks after which a partial frame is discarded
MEM_TIMEOUT, 4096, clocks to wait for mem_busy low or mem_rd_rdy before aborting
CONST_VAL, 259, value returned by CONST

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse, rx_data valid (uart_rx rcv)
rx_data  in  8  received byte
tx_ready  in  1  uart_tx ready
tx_start  out  1  uart_tx start
tx_data  out  8  byte to transmit
mem_addr  out  ADDR_W  address register
mem_wr_d  out  DATA_W  write-data register
mem_wr_req  out  1  one-cycle write request
mem_rd_req  out  1  one-cycle read request
mem_rd_d  in  DATA_W  read data
mem_rd_rdy  in  1  read data valid pulse
mem_busy  in  1  memory controller busy
cmd_active  out  1  high from first frame byte until last response byte accepted
err_pulse  out  1  one-cycle pulse on any error event

Behaviour:
- Reset (async, rstn=0): all outputs 0; address, write-data, read-latch, count, err_cnt registers 0; FSM to RX; byte counter 0.
- States: RX -> EXEC -> (MEM_ISSUE -> MEM_WAIT) -> TX_DRIVE <-> TX_SHIFT -> RX.
- RX:
  - Each rx_valid shifts rx_data into the frame register and increments the byte counter.
  - When the counter reaches DATA_BYTES+1, go to EXEC next cycle and clear the counter.
  - An idle counter resets on every rx_valid. If the counter is >0 and idle reaches RX_TIMEOUT: discard the frame, clear the counter, err_pulse, err_cnt++.
- EXEC (one cycle), by command byte; response word R:
  - 0x01 ADDR: mem_addr <= payload[ADDR_W-1:0]; R = payload.
  - 0x02 LOAD: mem_wr_d <= payload; R = payload.
  - 0x03 WRITE: go MEM_ISSUE (write); R = 0x03 on success.
  - 0x04 READ: R = last latched read data.
  - 0x05 READ_REQ: go MEM_ISSUE (read); R = read data.
  - 0x06 COUNT: R = count; count++ (wraps at DATA_W).
  - 0x07 CONST: R = CONST_VAL.
  - 0x08 STATUS: R = {zeros, err_cnt[7:0], last_cmd[7:0]}; err_cnt is not cleared.
  - Other: R = all-ones; err_pulse; err_cnt++.
- MEM_ISSUE:
  - Wait for mem_busy=0, then pulse mem_wr_req or mem_rd_req for exactly one cycle.
  - Write: go straight to TX.
  - Read: go to MEM_WAIT.
- MEM_WAIT: mem_rd_rdy latches mem_rd_d into the read latch and into R; go to TX. A mem_rd_rdy arriving in any other state still updates the read latch.
- Memory timeout: the wait counter covers MEM_ISSUE+MEM_WAIT. On reaching MEM_TIMEOUT: R = all-ones, err_pulse, err_cnt++, go to TX. No request is issued after the timeout.
- TX (exactly DATA_BYTES bytes, MSB first):
  - TX_DRIVE: when tx_ready=1, set tx_start=1 and tx_data = R MSB byte.
  - tx_start is held high until tx_ready is sampled 0 (falling edge of ready, not its level).
  - TX_SHIFT: tx_start=0, R <<= 8, decrement the byte counter. Return to TX_DRIVE until done, then go to RX.
- Overrun: an rx_valid outside RX drops the byte, err_pulse, err_cnt++.
- err_cnt is 8 bits and saturates at 255.
- last_cmd is updated in EXEC for every frame.
- cmd_active is 1 in all non-RX states, and also in RX when the byte counter is >0.

Optional Feature:
AUTOINC_EN:
- Defined: mem_addr increments by 1 (wrapping at ADDR_W) one cycle after each successful WRITE request pulse or READ_REQ data capture. Not incremented on timeout.
- Undefined: mem_addr changes only on ADDR.

Test Plan:
- ADDR frame 01 00 00 00 2A -> response 00 00 00 2A; mem_addr=0x2A; exactly 4 tx_start pulses.
- LOAD 02 DE AD BE EF, then WRITE 03 00 00 00 00 with mem_busy held 10 cycles -> mem_wr_req one-cycle pulse after busy drops; mem_wr_d=DEADBEEF; response 00 00 00 03.
- READ_REQ with mem_rd_d=0x12345678 and mem_rd_rdy 5 cycles after req -> response 12 34 56 78; a following READ returns the same bytes; with AUTOINC_EN, mem_addr advanced by 1.
- Send 2 bytes, then idle RX_TIMEOUT cycles -> err_pulse, frame discarded; next full CONST frame returns 00 00 01 03.
- READ_REQ with mem_rd_rdy never asserted -> after MEM_TIMEOUT response FF FF FF FF; STATUS returns 00 00 01 05.
- Unknown cmd 0x99 -> FF FF FF FF; an rx byte injected during TX is dropped; STATUS then shows err_cnt=2, last_cmd=0x99; rstn pulse mid-TX -> tx_start=0 immediately, FSM to RX.
